alu_ctl_seq: RTL and testbench
==============================

// Module: alu_ctl_seq
// PURPOSE
//  Registered, parametrised successor to the combinational ALU control decode.
//  Maps ALUOp/funct to the ALU control code, flags illegal functs, and sequences
//  multi-cycle mult/div ops with a cycle counter and a ready/valid handshake.
//  Sits between the ID/EX register and the ALU/mult-div unit. Drives the stall
//  request seen by the hazard unit.
// PARAMETERS
//  CTL_W      4   ALU control code width; codes below fit in 4 bits
//  FUNCT_W    6   funct field width
//  MD_CYCLES  32  EX cycles a mult/div occupies; must be >= 2
//  CNT_W      $clog2(MD_CYCLES)  down-counter width (derived, not overridden)
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        alu_op/funct valid this cycle
//  in_ready   out  1        block can accept; combinational: 1 iff state==IDLE
//  alu_op     in   2        00 add, 01 sub, 10 use funct, 11 or (ori)
//  funct      in   FUNCT_W  R-type funct field
//  flush      in   1        synchronous abort of any in-flight op
//  alu_ctl    out  CTL_W    registered ALU control code
//  out_valid  out  1        alu_ctl/illegal valid (1-cycle pulse per accepted op)
//  illegal    out  1        accepted funct not in decode table
//  md_start   out  1        pulse: mult/div launched (coincides with out_valid)
//  md_busy    out  1        mult/div in progress
//  md_done    out  1        pulse: mult/div finished
//  hilo_we    out  1        HI/LO write enable; pulses with md_done
//  stall      out  1        = md_busy | (state==MD_DONE); to hazard unit
// BEHAVIOUR
//  Reset: alu_ctl=4'hF; out_valid, illegal, md_start, md_busy, md_done, hilo_we=0.
//  Reset also sets state=IDLE and cnt=0. Reset overrides flush and in_valid.
//  Accept = in_valid & in_ready. Decode is registered: outputs valid 1 cycle after accept.
//  alu_op 00->2, 01->6, 11->1, 10->funct table:
//    32/33 add->2, 34/35 sub->6, 36 and->0, 37 or->1, 38 xor->3, 39 nor->12
//    42 slt->7, 43 sltu->8, 24/25 mult->9, 26/27 div->10
//  Funct not in table: alu_ctl=15, illegal=1, treated as single-cycle.
//  FSM IDLE->MD_RUN: on accept of funct 24..27 with alu_op=10; load cnt=MD_CYCLES-2.
//    md_start and out_valid pulse on the cycle after accept.
//  MD_RUN: md_busy=1, in_ready=0. cnt decrements each cycle.
//    MD_RUN->MD_DONE when cnt==0.
//  MD_DONE: one cycle; md_done=hilo_we=1. Then ->IDLE. in_ready returns next cycle.
//  Busy window: MD_CYCLES cycles from the md_start cycle through md_done inclusive.
//  Single-cycle op: state stays IDLE; back-to-back accepts every cycle allowed.
//  flush in any state: ->IDLE next cycle, cnt=0, and suppresses that cycle's accept.
//    No md_done/hilo_we for the aborted op; out_valid=0 on the next cycle.
//  Flush in the MD_DONE cycle: hilo_we still asserts that cycle (commit already made).
//  alu_ctl holds its last value when out_valid=0.
// CONFIGURATION
//  ALU_SHIFT_EN defined: funct 0 sll->4, 2 srl->5, 3 sra->11, all single-cycle, legal.
//  ALU_SHIFT_EN undefined: funct 0/2/3 decode as illegal (alu_ctl=15, illegal=1).
// STRUCTURE
//  alu_ctl_pkg holds:
//    ALU control code localparams (ALU_AND..ALU_BAD=15) and funct localparams.
//    ALUOp encodings and the FSM state encoding (IDLE, MD_RUN, MD_DONE).
//  Sub-module alu_funct_dec: combinational funct/alu_op -> {code, illegal, is_md}.
//    Its outputs are registered by alu_ctl_seq.
//  The FSM and counter live in the top.
// TESTING
//  1. reset=1 for 2 cycles -> alu_ctl=15 and all pulses 0.
//     Release reset -> in_ready=1.
//  2. Back-to-back alu_op=10, funct 32,34,36,37,39,42 on consecutive cycles ->
//     alu_ctl 2,6,0,1,12,7, each 1 cycle later, with out_valid held high.
//  3. alu_op=10, funct=24, MD_CYCLES=32 ->
//     md_start at T+1; in_ready low T+1..T+32; md_done/hilo_we at T+32 only.
//  4. mult accepted, flush 5 cycles later ->
//     IDLE next cycle, no md_done/hilo_we, in_ready=1.
//     Repeat with flush and in_valid together -> op dropped, out_valid=0.
//  5. funct=0: without ALU_SHIFT_EN -> alu_ctl=15, illegal=1.
//     With ALU_SHIFT_EN -> alu_ctl=4, illegal=0. funct=3 with it -> alu_ctl=11.
//  6. reset asserted mid-MD_RUN ->
//     next cycle IDLE, md_busy=0, alu_ctl=15, no hilo_we.

Source files
------------

// File: rtl/alu_ctl_pkg.sv
// Shared encodings for the registered ALU control sequencer: ALU control codes,
// R-type funct values, ALUOp encodings and the mult/div FSM state.
package alu_ctl_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_MULT = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_NOR  = 4'd12;
    localparam logic [3:0] ALU_BAD  = 4'd15;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctl_seq_if.sv
// Decode/handshake bundle between the ID/EX stage (master) and alu_ctl_seq (slave).
interface alu_ctl_seq_if #(
    parameter int CTL_W   = 4,
    parameter int FUNCT_W = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               flush;
    logic [CTL_W-1:0]   alu_ctl;
    logic               out_valid;
    logic               illegal;
    logic               md_start;
    logic               md_busy;
    logic               md_done;
    logic               hilo_we;
    logic               stall;

    modport master (
        output in_valid, alu_op, funct, flush,
        input  in_ready, alu_ctl, out_valid, illegal,
               md_start, md_busy, md_done, hilo_we, stall
    );

    modport slave (
        input  in_valid, alu_op, funct, flush,
        output in_ready, alu_ctl, out_valid, illegal,
               md_start, md_busy, md_done, hilo_we, stall
    );
endinterface

// File: rtl/alu_funct_dec.sv
// Combinational ALUOp/funct decode to {code, illegal, is_md}.
// Shift functs decode as legal only when ALU_SHIFT_EN is defined.
module alu_funct_dec
    import alu_ctl_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [3:0]         code,
    output logic               illegal,
    output logic               is_md
);

    // Decode table lookup; anything unlisted becomes ALU_BAD with illegal set.
    always_comb begin
        code    = ALU_BAD;
        illegal = 1'b0;
        is_md   = 1'b0;
        case (alu_op)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_OR:  code = ALU_OR;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_W'(FN_ADD),  FUNCT_W'(FN_ADDU): code = ALU_ADD;
                    FUNCT_W'(FN_SUB),  FUNCT_W'(FN_SUBU): code = ALU_SUB;
                    FUNCT_W'(FN_AND):  code = ALU_AND;
                    FUNCT_W'(FN_OR):   code = ALU_OR;
                    FUNCT_W'(FN_XOR):  code = ALU_XOR;
                    FUNCT_W'(FN_NOR):  code = ALU_NOR;
                    FUNCT_W'(FN_SLT):  code = ALU_SLT;
                    FUNCT_W'(FN_SLTU): code = ALU_SLTU;
                    FUNCT_W'(FN_MULT), FUNCT_W'(FN_MULTU): begin
                        code  = ALU_MULT;
                        is_md = 1'b1;
                    end
                    FUNCT_W'(FN_DIV),  FUNCT_W'(FN_DIVU): begin
                        code  = ALU_DIV;
                        is_md = 1'b1;
                    end
`ifdef ALU_SHIFT_EN
                    FUNCT_W'(FN_SLL):  code = ALU_SLL;
                    FUNCT_W'(FN_SRL):  code = ALU_SRL;
                    FUNCT_W'(FN_SRA):  code = ALU_SRA;
`endif
                    default: begin
                        code    = ALU_BAD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                code    = ALU_BAD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctl_seq.sv
// Registered ALU control decode with a mult/div sequencer and ready/valid handshake.
// Optional shift decode is enabled by defining ALU_SHIFT_EN.
module alu_ctl_seq
    import alu_ctl_pkg::*;
#(
    parameter int CTL_W     = 4,
    parameter int FUNCT_W   = 6,
    parameter int MD_CYCLES = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_ctl_seq_if.slave bus
);

    localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

    state_e             state_r;
    state_e             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [CTL_W-1:0]   alu_ctl_r;
    logic               illegal_r;
    logic               out_valid_r;
    logic               md_start_r;
    logic               in_ready_s;
    logic               accept_s;
    logic [3:0]         dec_code_s;
    logic               dec_illegal_s;
    logic               dec_is_md_s;

    alu_funct_dec #(
        .FUNCT_W (FUNCT_W)
    ) u_dec (
        .alu_op  (bus.alu_op),
        .funct   (bus.funct),
        .code    (dec_code_s),
        .illegal (dec_illegal_s),
        .is_md   (dec_is_md_s)
    );

    assign in_ready_s = (state_r == IDLE);
    // Flush kills the handshake in the same cycle it is raised.
    assign accept_s   = bus.in_valid & in_ready_s & ~bus.flush;

    // Next-state and counter logic for the mult/div sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (bus.flush) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && dec_is_md_s) begin
                        state_nxt_s = MD_RUN;
                        cnt_nxt_s   = CNT_W'(MD_CYCLES - 2);
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                MD_RUN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = MD_DONE;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end
                end
                MD_DONE: state_nxt_s = IDLE;
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, counter and registered decode outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            alu_ctl_r   <= CTL_W'(ALU_BAD);
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b0;
            md_start_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= accept_s;
            md_start_r  <= accept_s & dec_is_md_s;
            if (accept_s) begin
                alu_ctl_r <= CTL_W'(dec_code_s);
                illegal_r <= dec_illegal_s;
            end else begin
                alu_ctl_r <= alu_ctl_r;
                illegal_r <= illegal_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.alu_ctl   = alu_ctl_r;
    assign bus.out_valid = out_valid_r;
    assign bus.illegal   = illegal_r;
    assign bus.md_start  = md_start_r;
    assign bus.md_busy   = (state_r == MD_RUN);
    // HI/LO commit follows the state register, so a flush in MD_DONE cannot retract it.
    assign bus.md_done   = (state_r == MD_DONE);
    assign bus.hilo_we   = (state_r == MD_DONE);
    assign bus.stall     = (state_r == MD_RUN) | (state_r == MD_DONE);

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Directed self-checking bench for alu_ctl_seq (MD_CYCLES=32); shift
// expectations follow ALU_SHIFT_EN.
module tb_alu_ctl_seq;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_ctl_seq_if #(.CTL_W(4), .FUNCT_W(6)) bus ();

    alu_ctl_seq #(
        .CTL_W     (4),
        .FUNCT_W   (6),
        .MD_CYCLES (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [5:0] fn_tab  [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    logic [3:0] ctl_tab [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7};
    logic       seen_s;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.alu_op   = 2'b00;
        bus.funct    = 6'd0;
        bus.flush    = 1'b0;

        // 1. reset
        tick(); tick();
        chk("rst_alu_ctl", bus.alu_ctl, 32'hF);
        chk("rst_out_valid", bus.out_valid, 32'h0);
        chk("rst_illegal", bus.illegal, 32'h0);
        chk("rst_md_start", bus.md_start, 32'h0);
        chk("rst_md_busy", bus.md_busy, 32'h0);
        chk("rst_md_done", bus.md_done, 32'h0);
        chk("rst_hilo_we", bus.hilo_we, 32'h0);
        reset = 1'b0;
        tick();
        chk("rel_in_ready", bus.in_ready, 32'h1);

        // 2. back-to-back R-type decode
        bus.alu_op   = 2'b10;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.funct = fn_tab[i];
            tick();
            chk("b2b_out_valid", bus.out_valid, 32'h1);
            chk("b2b_alu_ctl", bus.alu_ctl, 32'(ctl_tab[i]));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("idle_out_valid", bus.out_valid, 32'h0);
        chk("hold_alu_ctl", bus.alu_ctl, 32'd7);

        // non-funct ALUOp encodings
        bus.in_valid = 1'b1;
        bus.funct    = 6'd0;
        bus.alu_op   = 2'b00; tick(); chk("aluop00", bus.alu_ctl, 32'd2);
        bus.alu_op   = 2'b01; tick(); chk("aluop01", bus.alu_ctl, 32'd6);
        bus.alu_op   = 2'b11; tick(); chk("aluop11", bus.alu_ctl, 32'd1);
        chk("aluop11_illegal", bus.illegal, 32'h0);

        // 3. mult timing with a blocked op waiting behind it
        bus.alu_op = 2'b10;
        bus.funct  = 6'd24;
        tick();
        chk("mult_md_start", bus.md_start, 32'h1);
        chk("mult_out_valid", bus.out_valid, 32'h1);
        chk("mult_alu_ctl", bus.alu_ctl, 32'd9);
        chk("mult_in_ready", bus.in_ready, 32'h0);
        chk("mult_md_busy", bus.md_busy, 32'h1);
        bus.funct = 6'd36;
        for (int k = 2; k <= 32; k++) begin
            tick();
            chk("run_in_ready", bus.in_ready, 32'h0);
            chk("run_out_valid", bus.out_valid, 32'h0);
            chk("run_md_done", bus.md_done, 32'(k == 32));
            chk("run_hilo_we", bus.hilo_we, 32'(k == 32));
            chk("run_stall", bus.stall, 32'h1);
        end
        tick();
        chk("post_in_ready", bus.in_ready, 32'h1);
        chk("post_md_done", bus.md_done, 32'h0);
        chk("post_stall", bus.stall, 32'h0);
        tick();
        chk("queued_out_valid", bus.out_valid, 32'h1);
        chk("queued_alu_ctl", bus.alu_ctl, 32'd0);
        bus.in_valid = 1'b0;

        // 4. flush 5 cycles after accept
        bus.in_valid = 1'b1;
        bus.funct    = 6'd25;
        tick();
        chk("f_md_start", bus.md_start, 32'h1);
        bus.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("f_in_ready", bus.in_ready, 32'h1);
        chk("f_md_busy", bus.md_busy, 32'h0);
        chk("f_stall", bus.stall, 32'h0);
        seen_s = 1'b0;
        for (int k = 0; k < 34; k++) begin
            tick();
            if (bus.md_done || bus.hilo_we) seen_s = 1'b1;
        end
        chk("f_no_done", 32'(seen_s), 32'h0);

        // flush together with in_valid drops the op
        bus.in_valid = 1'b1;
        bus.funct    = 6'd32;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fv_out_valid", bus.out_valid, 32'h0);
        chk("fv_alu_ctl", bus.alu_ctl, 32'd9);
        chk("fv_in_ready", bus.in_ready, 32'h1);

        // flush in the MD_DONE cycle keeps the HI/LO commit
        bus.in_valid = 1'b1;
        bus.funct    = 6'd26;
        tick();
        bus.in_valid = 1'b0;
        chk("d_alu_ctl", bus.alu_ctl, 32'd10);
        for (int k = 2; k <= 32; k++) tick();
        bus.flush = 1'b1;
        chk("d_hilo_we", bus.hilo_we, 32'h1);
        tick();
        bus.flush = 1'b0;
        chk("d_after_hilo_we", bus.hilo_we, 32'h0);
        chk("d_after_in_ready", bus.in_ready, 32'h1);

        // 5. shift functs and illegal decode
        bus.in_valid = 1'b1;
        bus.funct    = 6'd0;
        tick();
`ifdef ALU_SHIFT_EN
        chk("sll_alu_ctl", bus.alu_ctl, 32'd4);
        chk("sll_illegal", bus.illegal, 32'h0);
`else
        chk("sll_alu_ctl", bus.alu_ctl, 32'd15);
        chk("sll_illegal", bus.illegal, 32'h1);
`endif
        bus.funct = 6'd3;
        tick();
`ifdef ALU_SHIFT_EN
        chk("sra_alu_ctl", bus.alu_ctl, 32'd11);
`else
        chk("sra_alu_ctl", bus.alu_ctl, 32'd15);
`endif
        chk("sra_in_ready", bus.in_ready, 32'h1);
        bus.funct = 6'd40;
        tick();
        chk("bad_alu_ctl", bus.alu_ctl, 32'd15);
        chk("bad_illegal", bus.illegal, 32'h1);
        chk("bad_md_start", bus.md_start, 32'h0);
        bus.funct = 6'd43;
        tick();
        chk("sltu_alu_ctl", bus.alu_ctl, 32'd8);
        chk("sltu_illegal", bus.illegal, 32'h0);

        // 6. reset mid-MD_RUN
        bus.funct = 6'd27;
        tick();
        bus.in_valid = 1'b0;
        chk("r_md_busy_pre", bus.md_busy, 32'h1);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_md_busy", bus.md_busy, 32'h0);
        chk("r_alu_ctl", bus.alu_ctl, 32'hF);
        chk("r_in_ready", bus.in_ready, 32'h1);
        chk("r_out_valid", bus.out_valid, 32'h0);
        chk("r_hilo_we", bus.hilo_we, 32'h0);
        seen_s = 1'b0;
        for (int k = 0; k < 34; k++) begin
            tick();
            if (bus.hilo_we || bus.md_busy) seen_s = 1'b1;
        end
        chk("r_no_hilo", 32'(seen_s), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
